// File: rtl/busca_instrucao_if.sv
// Instruction-memory bus between the fetch sequencer (master) and the synchronous ROM (slave).
// Read data is valid the cycle after imem_rd is sampled high.
interface busca_instrucao_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rd;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_data
    );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch/issue sequencer: FETCH -> LOAD -> ISSUE per word, halts on the decoder's Stop.
// Every output is a register or a direct view of one.
module busca_instrucao #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                Stop,
    busca_instrucao_if.master   imem,
    output logic [2:0]          OpCode,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               rd_q;
    logic               valid_q;
    logic               halted_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Saturating retire count; the stop instruction is counted like any other.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Sequencer state machine with its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            rd_q     <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        rd_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                    rd_q    <= 1'b0;
                end
                S_LOAD: begin
                    state_q <= S_ISSUE;
                    ir_q    <= imem.imem_data;
                    pc_q    <= pc_q + PC_ONE;
                    valid_q <= 1'b1;
                end
                S_ISSUE: begin
                    // While stalled the issued word is held and Stop is not yet honoured.
                    if (!stall) begin
                        cnt_q   <= cnt_d;
                        valid_q <= 1'b0;
                        if (Stop) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            rd_q    <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        pc_q     <= '0;
                        cnt_q    <= '0;
                        rd_q     <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    rd_q     <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = rd_q;
    assign OpCode         = ir_q[INSTR_W-1 -: 3];
    assign instr          = ir_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign instr_count    = cnt_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: an 8-bit-address instance for sequencing/stall/reset
// and a 2-bit-address instance for PC wrap, each with a behavioural ROM and Stop decoder.
module tb_busca_instrucao;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, stall0, start1, stall1;
    logic stop0, stop1;

    logic [2:0]  op0, op1;
    logic [15:0] instr0, instr1;
    logic        valid0, valid1, halted0, halted1;
    logic [7:0]  pc0;
    logic [1:0]  pc1;
    logic [15:0] cnt0, cnt1;

    logic [15:0] rom0 [256];
    logic [15:0] rom1 [4];

    int checks = 0;
    int failures = 0;

    busca_instrucao_if #(.ADDR_W(8), .INSTR_W(16)) bus0 ();
    busca_instrucao_if #(.ADDR_W(2), .INSTR_W(16)) bus1 ();

    busca_instrucao #(.ADDR_W(8), .INSTR_W(16), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start0), .stall(stall0), .Stop(stop0),
        .imem(bus0), .OpCode(op0), .instr(instr0), .instr_valid(valid0),
        .pc(pc0), .halted(halted0), .instr_count(cnt0)
    );

    busca_instrucao #(.ADDR_W(2), .INSTR_W(16), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stall(stall1), .Stop(stop1),
        .imem(bus1), .OpCode(op1), .instr(instr1), .instr_valid(valid1),
        .pc(pc1), .halted(halted1), .instr_count(cnt1)
    );

    // Decoder model: opcode 101 is the stop instruction.
    assign stop0 = (op0 == 3'b101);
    assign stop1 = (op1 == 3'b101);

    // Synchronous ROMs.
    always_ff @(posedge clk) begin
        if (bus0.imem_rd) bus0.imem_data <= rom0[bus0.imem_addr];
        if (bus1.imem_rd) bus1.imem_data <= rom1[bus1.imem_addr];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; stall0 = 1'b0; start1 = 1'b0; stall1 = 1'b0;
        for (int i = 0; i < 256; i++) rom0[i] = 16'h0000;
        rom1[0] = 16'h0000; rom1[1] = 16'h2000; rom1[2] = 16'h4000; rom1[3] = 16'h6000;

        // Reset for two cycles, then idle for five.
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_eq("idle_rd", 32'(bus0.imem_rd), 32'd0);
            chk_eq("idle_valid", 32'(valid0), 32'd0);
        end
        chk_eq("rst_pc", 32'(pc0), 32'd0);
        chk_eq("rst_addr", 32'(bus0.imem_addr), 32'd0);
        chk_eq("rst_instr", 32'(instr0), 32'd0);
        chk_eq("rst_op", 32'(op0), 32'd0);
        chk_eq("rst_halted", 32'(halted0), 32'd0);
        chk_eq("rst_cnt", 32'(cnt0), 32'd0);
        chk_eq("rst_halted1", 32'(halted1), 32'd0);

        // Basic sequence add, sub, stop; a start pulse during LOAD must be ignored.
        rom0[0] = 16'h0000; rom0[1] = 16'h2000; rom0[2] = 16'hA000;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk_eq($sformatf("seq_valid_c%0d", c), 32'(valid0), 32'((c == 3) || (c == 6) || (c == 9)));
            chk_eq($sformatf("seq_rd_c%0d", c), 32'(bus0.imem_rd), 32'((c == 1) || (c == 4) || (c == 7)));
            chk_eq($sformatf("seq_halted_c%0d", c), 32'(halted0), 32'(c == 10));
            if (c == 3) chk_eq("seq_op0", 32'(op0), 32'd0);
            if (c == 6) chk_eq("seq_op1", 32'(op0), 32'd1);
            if (c == 9) chk_eq("seq_op2", 32'(op0), 32'd5);
            if (c == 9) chk_eq("seq_instr2", 32'(instr0), 32'hA000);
            start0 = (c == 5);
            tick();
        end
        start0 = 1'b0;
        chk_eq("seq_cnt", 32'(cnt0), 32'd3);
        chk_eq("seq_pc", 32'(pc0), 32'd3);
        chk_eq("seq_addr", 32'(bus0.imem_addr), 32'd3);
        chk_eq("seq_halted_hold", 32'(halted0), 32'd1);
        tick(); tick();
        chk_eq("halt_pc_frozen", 32'(pc0), 32'd3);
        chk_eq("halt_cnt_frozen", 32'(cnt0), 32'd3);
        chk_eq("halt_rd", 32'(bus0.imem_rd), 32'd0);

        // Restart from HALT with a 4-cycle stall on instr 0 and a 2-cycle stall on the stop.
        rom0[0] = 16'h0000; rom0[1] = 16'hA000;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c == 1) begin
                chk_eq("rs_pc", 32'(pc0), 32'd0);
                chk_eq("rs_cnt", 32'(cnt0), 32'd0);
                chk_eq("rs_halted", 32'(halted0), 32'd0);
                chk_eq("rs_rd", 32'(bus0.imem_rd), 32'd1);
            end
            if (c >= 3 && c <= 7) begin
                chk_eq($sformatf("st_valid_c%0d", c), 32'(valid0), 32'd1);
                chk_eq($sformatf("st_op_c%0d", c), 32'(op0), 32'd0);
                chk_eq($sformatf("st_pc_c%0d", c), 32'(pc0), 32'd1);
                chk_eq($sformatf("st_cnt_c%0d", c), 32'(cnt0), 32'd0);
            end
            if (c == 8) begin
                chk_eq("st_fetch_rd", 32'(bus0.imem_rd), 32'd1);
                chk_eq("st_cnt_once", 32'(cnt0), 32'd1);
            end
            if (c >= 10 && c <= 12) begin
                chk_eq($sformatf("ss_valid_c%0d", c), 32'(valid0), 32'd1);
                chk_eq($sformatf("ss_halted_c%0d", c), 32'(halted0), 32'd0);
                chk_eq($sformatf("ss_cnt_c%0d", c), 32'(cnt0), 32'd1);
            end
            if (c == 13) begin
                chk_eq("ss_halted", 32'(halted0), 32'd1);
                chk_eq("ss_valid", 32'(valid0), 32'd0);
                chk_eq("ss_cnt", 32'(cnt0), 32'd2);
            end
            stall0 = ((c >= 3) && (c <= 6)) || (c == 10) || (c == 11);
            tick();
        end
        stall0 = 1'b0;

        // Reset asserted during LOAD together with start.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        rst = 1'b1; start0 = 1'b1;
        tick();
        chk_eq("mr_valid", 32'(valid0), 32'd0);
        chk_eq("mr_pc", 32'(pc0), 32'd0);
        chk_eq("mr_instr", 32'(instr0), 32'd0);
        chk_eq("mr_halted", 32'(halted0), 32'd0);
        chk_eq("mr_rd", 32'(bus0.imem_rd), 32'd0);
        rst = 1'b0; start0 = 1'b0;
        tick(); tick();
        chk_eq("mr_idle_rd", 32'(bus0.imem_rd), 32'd0);
        chk_eq("mr_idle_valid", 32'(valid0), 32'd0);

        // PC wrap on the 2-bit instance.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c % 3 == 0) chk_eq($sformatf("wrap_pc_c%0d", c), 32'(pc1), 32'((c / 3) % 4));
            if (c == 13) begin
                chk_eq("wrap_addr5", 32'(bus1.imem_addr), 32'd0);
                chk_eq("wrap_rd5", 32'(bus1.imem_rd), 32'd1);
            end
            if (c == 15) begin
                chk_eq("wrap_op", 32'(op1), 32'd0);
                chk_eq("wrap_cnt", 32'(cnt1), 32'd4);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
- Instruction fetch/issue sequencer directly upstream of the control decoder.
- Holds the PC and fetches words from a synchronous instruction ROM into an instruction register (IR).
- Presents IR[15:13] as OpCode to the decoder and the remaining fields to the datapath, one instruction at a time.
- Consumes the decoder's Stop signal to halt; a stall input from the datapath/memory freezes issue.

Parameters:
- ADDR_W, 8, PC and instruction-ROM address width (ROM depth 2^ADDR_W words).
- INSTR_W, 16, instruction word width. Opcode field is always IR[INSTR_W-1:INSTR_W-3].
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. Starts execution from PC 0 when in IDLE or HALT; ignored in other states.
- stall  in  1  datapath not ready to accept the issued instruction; holds ISSUE.
- Stop  in  1  from decoder, combinational function of OpCode; sampled only in ISSUE.
- imem_addr  out  ADDR_W  ROM address.
- imem_rd  out  1  ROM read strobe.
- imem_data  in  INSTR_W  ROM read data, valid the cycle after imem_rd.
- OpCode  out  3  IR opcode field, to decoder.
- instr  out  INSTR_W  full IR, to datapath.
- instr_valid  out  1  IR holds an issued instruction this cycle.
- pc  out  ADDR_W  address of the next word to fetch.
- halted  out  1  block is in HALT.
- instr_count  out  CNT_W  number of instructions retired since the last start.

Behaviour:
- States: IDLE, FETCH, LOAD, ISSUE, HALT. All are registered; outputs are decoded from state and registers.
- Reset values: state=IDLE, pc=0, IR=0, imem_addr=0, imem_rd=0, instr_valid=0, halted=0, instr_count=0.
  - rst overrides everything, including mid-instruction and a simultaneous start.
- IDLE: start=1 -> FETCH, with pc<=0 and instr_count<=0. Otherwise stay.
- FETCH: imem_rd=1, imem_addr=pc. Next state LOAD unconditionally.
- LOAD: IR<=imem_data; pc<=pc+1, modulo 2^ADDR_W (pc=all-ones wraps to 0, no flag). Next state ISSUE.
- ISSUE: instr_valid=1; OpCode=IR opcode field.
  - stall=1: stay in ISSUE. IR, pc and instr_count are held; instr_valid stays 1; Stop is ignored.
  - stall=0, Stop=1: instruction retires, instr_count increments, next state HALT.
  - stall=0, Stop=0: instruction retires, instr_count increments, next state FETCH.
- HALT: halted=1, instr_valid=0, imem_rd=0.
  - start=1 -> FETCH, with pc<=0 and instr_count<=0.
  - Otherwise stay; pc, IR and instr_count are frozen.
- instr_valid=0 in every state except ISSUE. Downstream must qualify RegEsc, MemEn and Clear with instr_valid, because IR=0 decodes as add.
- OpCode and instr always reflect IR, including outside ISSUE.
- imem_rd=1 only in FETCH. imem_addr holds pc in every state.
- instr_count saturates at all-ones. It increments exactly once per retired instruction, and the stop instruction is counted.
- Throughput: 3 cycles per instruction with no stall.
  - start sampled at edge 0 -> FETCH in cycle 1, LOAD in cycle 2, instr_valid=1 in cycle 3.
  - Each stall cycle adds one cycle.
- start arriving in FETCH, LOAD or ISSUE is ignored.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then idle for 5 cycles -> all outputs at their reset values, imem_rd never asserted.
- Basic sequence: ROM[0]=0x0000 (add), ROM[1]=0x2000 (sub), ROM[2]=0xA000 (stop, opcode 101); pulse start.
  - instr_valid high in cycles 3, 6 and 9 with OpCode 000, 001, 101 respectively.
  - halted=1 from cycle 10; instr_count=3; pc=3.
- Stall: stall=1 for 4 cycles while in ISSUE of instruction 0 -> instr_valid held 4 extra cycles, OpCode stable, pc=1 throughout, instr_count increments only once after stall drops.
- Stop under stall: stop instruction issued with stall=1 for 2 cycles -> no HALT until stall=0, then HALT the next cycle; instr_count counts the stop once.
- PC wrap: ADDR_W=2, ROM[0..3] all non-stop, ROM[0] reached again -> pc sequence 1,2,3,0,1 after each LOAD; imem_addr=0 on the fifth fetch.
- Restart/reset mid-run: from HALT, pulse start -> pc=0, instr_count=0, fetch restarts. Assert rst during LOAD -> next cycle state IDLE, IR=0, instr_valid=0, pc=0.
